apb_periph_node: RTL and testbench
==================================

Name: apb_periph_node

Overview:
- Parametrised, registered APB node between the AXI-to-APB bridge and a variable number of APB peripherals. Next generation of the fixed 4-slave, 12-bit peripheral fan-out.
- Decodes one upstream APB port to NUM_SLAVES downstream ports.
- Inserts one register stage for timing closure.
- Unmapped accesses return PSLVERR. An optional watchdog aborts accesses to hung slaves.

Parameters:
- NUM_SLAVES, 8, number of downstream APB ports (1..32).
- ADDR_WIDTH, 32, upstream address width.
- DATA_WIDTH, 32, APB data width.
- SLAVE_ADDR_BITS, 12, per-slave region size is 2^SLAVE_ADDR_BITS bytes; also the downstream paddr width.
- BASE_ADDR, 32'h1A10_0000, node base address; must be aligned to 2^(SLAVE_ADDR_BITS+IDX_W).
- TIMEOUT_CYCLES, 255, ACCESS-phase cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- psel_i  in  1  upstream select
- penable_i  in  1  upstream enable
- pwrite_i  in  1  upstream write
- paddr_i  in  ADDR_WIDTH  upstream address
- pwdata_i  in  DATA_WIDTH  upstream write data
- prdata_o  out  DATA_WIDTH  upstream read data
- pready_o  out  1  upstream ready
- pslverr_o  out  1  upstream error
- psel_o  out  NUM_SLAVES  one-hot downstream select
- penable_o  out  1  shared downstream enable
- pwrite_o  out  1  shared downstream write
- paddr_o  out  SLAVE_ADDR_BITS  shared downstream address
- pwdata_o  out  DATA_WIDTH  shared downstream write data
- prdata_i  in  NUM_SLAVES x DATA_WIDTH  per-slave read data
- pready_i  in  NUM_SLAVES  per-slave ready
- pslverr_i  in  NUM_SLAVES  per-slave error

Behaviour:
- Clock and reset: clk, rst. One clock domain; rst is synchronous and active-high.
- Outputs during rst: all outputs 0; FSM in IDLE; watchdog counter 0.
- Definitions:
  - IDX_W = max(1, clog2(NUM_SLAVES)).
  - Hit when paddr_i[ADDR_WIDTH-1 : SLAVE_ADDR_BITS+IDX_W] equals the same bits of BASE_ADDR, and idx = paddr_i[SLAVE_ADDR_BITS+IDX_W-1 : SLAVE_ADDR_BITS] is below NUM_SLAVES.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Triggered by psel_i && !penable_i (upstream setup).
  - Captures pwrite, paddr[SLAVE_ADDR_BITS-1:0], pwdata, idx and hit into registers.
  - Hit → SETUP. Miss → RESP with pslverr=1, prdata=0.
  - Any other input pattern is ignored.
- SETUP: psel_o[idx]=1, penable_o=0 → ACCESS.
- ACCESS:
  - Drives psel_o[idx]=1, penable_o=1.
  - On pready_i[idx]: capture prdata_i[idx] and pslverr_i[idx] → RESP.
- RESP:
  - psel_o=0, penable_o=0.
  - pready_o=1 for exactly one cycle, with the captured prdata_o and pslverr_o → IDLE.
- Between responses: prdata_o, pslverr_o and pready_o are 0 outside RESP.
- Downstream pwrite_o, paddr_o and pwdata_o are registered copies, stable from SETUP through ACCESS.
- Latency, counted from the upstream setup cycle T:
  - Miss: pready_o at T+1.
  - Hit with a zero-wait slave: downstream setup T+1, access T+2, pready_o at T+3.
  - Each slave wait state adds 1 cycle.
- Upstream rule: psel_i/penable_i are held until pready_o. If upstream deasserts mid-transfer, the node still completes the downstream access and issues RESP; a new setup is not accepted until IDLE.
- Selects: psel_o is one-hot or zero at all times. pready_i, pslverr_i and prdata_i of non-selected slaves are ignored.
- Reset mid-transfer: same cycle returns to IDLE, psel_o=0, no RESP issued.
- Single outstanding transfer; back-to-back setups are accepted in the cycle after RESP.

Optional Feature:
- Macro: APB_PERIPH_NODE_TIMEOUT_EN.
- Defined:
  - Counter clears on SETUP→ACCESS and increments each ACCESS cycle without pready_i[idx].
  - When the count reaches TIMEOUT_CYCLES, FSM → RESP with pslverr=1, prdata=0. psel_o/penable_o drop in that cycle.
  - pready_i arriving in the same cycle as the timeout wins (normal response).
- Undefined: no counter; ACCESS waits indefinitely.

Decomposition:
- Package apb_periph_node_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - the captured request struct (write, addr, wdata, idx, hit);
  - a decode function returning {hit, idx}.
- One sub-module, apb_periph_node_decode: combinational address decoder.
- The watchdog stays inline under the macro.

Test Plan:
- Write 32'hCAFE_0001 to 32'h1A10_2004 with slave 2 zero-wait → psel_o=8'b0000_0100, paddr_o=12'h004, pwdata_o=32'hCAFE_0001, pready_o at T+3, pslverr_o=0.
- Read 32'h1A10_5010 with slave 5 inserting 3 waits, prdata_i[5]=32'h1234_5678 → prdata_o=32'h1234_5678 with pready_o at T+6.
- Access 32'h1A20_0000 (outside base) and, with NUM_SLAVES=6, 32'h1A10_7000 → no psel_o, pready_o=1, pslverr_o=1, prdata_o=0 at T+1.
- Slave 1 returns pslverr_i=1 on a write → pslverr_o=1 in RESP; next transfer to slave 3 succeeds with pslverr_o=0.
- Timeout macro defined, TIMEOUT_CYCLES=16, slave 4 never ready → psel_o drops and pready_o=1, pslverr_o=1 after 16 ACCESS cycles; slave ready on exactly cycle 16 → normal response.
- rst asserted during ACCESS → next cycle all outputs 0, FSM IDLE; a following transfer completes normally.

Source files
------------

// File: rtl/apb_periph_node_pkg.sv
// Shared types and the address decode function for apb_periph_node.
// Struct fields are sized for the largest supported configuration
// (ADDR_WIDTH <= 64, DATA_WIDTH <= 64, SLAVE_ADDR_BITS <= 32, NUM_SLAVES <= 32).
package apb_periph_node_pkg;

  localparam int unsigned AddrMax      = 64;
  localparam int unsigned DataMax      = 64;
  localparam int unsigned SlaveAddrMax = 32;
  localparam int unsigned IdxMax       = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  typedef struct packed {
    logic                    write;
    logic [SlaveAddrMax-1:0] addr;
    logic [DataMax-1:0]      wdata;
    logic [IdxMax-1:0]       idx;
    logic                    hit;
  } req_t;

  // Returns {hit, idx}: the bits above the slave index must match the base and
  // the index must name an existing slave.
  function automatic logic [IdxMax:0] decode_addr(input logic [AddrMax-1:0] addr,
                                                  input logic [AddrMax-1:0] base,
                                                  input int unsigned slave_bits,
                                                  input int unsigned idx_w,
                                                  input int unsigned num_slaves);
    logic [AddrMax-1:0] mask;
    logic [AddrMax-1:0] idx_full;
    logic               hit;
    mask     = (AddrMax'(1) << idx_w) - AddrMax'(1);
    idx_full = (addr >> slave_bits) & mask;
    hit      = ((addr >> (slave_bits + idx_w)) == (base >> (slave_bits + idx_w))) &&
               (idx_full < AddrMax'(num_slaves));
    return {hit, IdxMax'(idx_full)};
  endfunction

endpackage

// File: rtl/apb_periph_node_decode.sv
// Combinational address decoder: upstream address to {hit, slave index}.
module apb_periph_node_decode
  import apb_periph_node_pkg::*;
#(
  parameter int unsigned           NUM_SLAVES      = 8,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           SLAVE_ADDR_BITS = 12,
  parameter int unsigned           IDX_W           = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(32'h1A10_0000)
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  logic [IdxMax:0] dec;

  // Decode the address against the node window.
  always_comb begin
    dec = decode_addr(AddrMax'(paddr), AddrMax'(BASE_ADDR), SLAVE_ADDR_BITS, IDX_W,
                      NUM_SLAVES);
    hit = dec[IdxMax];
    idx = IDX_W'(dec[IdxMax-1:0]);
  end

endmodule

// File: rtl/apb_periph_node.sv
// Registered APB fan-out node: one upstream port to NUM_SLAVES downstream ports.
// Optional ACCESS-phase watchdog enabled by defining APB_PERIPH_NODE_TIMEOUT_EN.
module apb_periph_node
  import apb_periph_node_pkg::*;
#(
  parameter int unsigned           NUM_SLAVES      = 8,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           SLAVE_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(32'h1A10_0000),
  parameter int unsigned           TIMEOUT_CYCLES  = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  psel_i,
  input  logic                                  penable_i,
  input  logic                                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0]                 paddr_i,
  input  logic [DATA_WIDTH-1:0]                 pwdata_i,
  output logic [DATA_WIDTH-1:0]                 prdata_o,
  output logic                                  pready_o,
  output logic                                  pslverr_o,
  output logic [NUM_SLAVES-1:0]                 psel_o,
  output logic                                  penable_o,
  output logic                                  pwrite_o,
  output logic [SLAVE_ADDR_BITS-1:0]            paddr_o,
  output logic [DATA_WIDTH-1:0]                 pwdata_o,
  input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]                 pready_i,
  input  logic [NUM_SLAVES-1:0]                 pslverr_i
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? int'($clog2(NUM_SLAVES)) : 1;

  state_e                  state_q, state_d;
  req_t                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [IDX_W-1:0]        cur_idx;
  logic [NUM_SLAVES-1:0]   sel_onehot;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    setup_req;
  logic                    timeout;
  logic                    unused_req;

  apb_periph_node_decode #(
    .NUM_SLAVES      (NUM_SLAVES),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS),
    .IDX_W           (IDX_W),
    .BASE_ADDR       (BASE_ADDR)
  ) u_decode (
    .paddr (paddr_i),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  assign setup_req  = psel_i && !penable_i;
  assign cur_idx    = IDX_W'(req_q.idx);
  // Padding bits of the wide request struct are intentionally dropped.
  assign unused_req = ^{req_q.addr, req_q.wdata, req_q.idx};

  // Select the captured slave; responses from all other slaves are ignored.
  always_comb begin
    sel_onehot = '0;
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
      if (cur_idx == IDX_W'(s)) begin
        sel_onehot[s] = 1'b1;
        sel_ready     = pready_i[s];
        sel_err       = pslverr_i[s];
        sel_rdata     = prdata_i[s];
      end
    end
  end

`ifdef APB_PERIPH_NODE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count ACCESS cycles without a ready; cleared as ACCESS is entered.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !sel_ready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // A ready in the final allowed cycle still wins over the timeout.
  assign timeout = (state_q == StAccess) && !sel_ready &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (setup_req) begin
          req_d.write = pwrite_i;
          req_d.addr  = SlaveAddrMax'(paddr_i[SLAVE_ADDR_BITS-1:0]);
          req_d.wdata = DataMax'(pwdata_i);
          req_d.idx   = IdxMax'(dec_idx);
          req_d.hit   = dec_hit;
          rdata_d     = '0;
          err_d       = !dec_hit;
          state_d     = dec_hit ? StSetup : StResp;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = sel_err;
          state_d = StResp;
        end else if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state; forced low while rst is asserted.
  always_comb begin
    psel_o    = '0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    paddr_o   = '0;
    pwdata_o  = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    if (!rst) begin
      if (req_q.hit && (state_q == StSetup || state_q == StAccess)) begin
        psel_o = sel_onehot;
      end
      penable_o = (state_q == StAccess);
      pwrite_o  = req_q.write;
      paddr_o   = SLAVE_ADDR_BITS'(req_q.addr);
      pwdata_o  = DATA_WIDTH'(req_q.wdata);
      if (state_q == StResp) begin
        pready_o  = 1'b1;
        pslverr_o = err_q;
        prdata_o  = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_periph_node.sv
// Self-checking bench for apb_periph_node (NUM_SLAVES=6, TIMEOUT_CYCLES=16).
module tb_apb_periph_node;

  localparam int unsigned NS = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              psel_i, penable_i, pwrite_i;
  logic [31:0]       paddr_i, pwdata_i;
  logic [31:0]       prdata_o;
  logic              pready_o, pslverr_o;
  logic [NS-1:0]     psel_o;
  logic              penable_o, pwrite_o;
  logic [11:0]       paddr_o;
  logic [31:0]       pwdata_o;
  logic [NS-1:0][31:0] prdata_i;
  logic [NS-1:0]     pready_i, pslverr_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_periph_node #(
    .NUM_SLAVES      (NS),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .SLAVE_ADDR_BITS (12),
    .BASE_ADDR       (32'h1A10_0000),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .paddr_i   (paddr_i),
    .pwdata_i  (pwdata_i),
    .prdata_o  (prdata_o),
    .pready_o  (pready_o),
    .pslverr_o (pslverr_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  // Slave models: selected slave is ready after slv_wait wait states; unselected
  // slaves drive ready/error high and junk data, which the node must ignore.
  int unsigned slv_wait  [NS];
  logic [31:0] slv_rdata [NS];
  logic        slv_err   [NS];
  int unsigned wcnt = 0;

  always @(posedge clk) begin
    if (psel_o != '0 && penable_o) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      pready_i[s]  = psel_o[s] ? (penable_o && wcnt == slv_wait[s]) : 1'b1;
      pslverr_i[s] = psel_o[s] ? slv_err[s] : 1'b1;
      prdata_i[s]  = psel_o[s] ? slv_rdata[s] : (32'hDEAD_0000 | 32'(s));
    end
  end

  typedef struct {
    string       name;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [NS-1:0] psel;
    logic        chk_dn;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [NS-1:0] psel;
    logic [NS-1:0] psel_resp;
    logic        onehot_ok;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  function automatic exp_t mk_exp(string name, int lat, logic [31:0] rdata, logic err,
                                  logic [NS-1:0] psel, logic chk_dn, logic pwrite,
                                  logic [11:0] paddr, logic [31:0] pwdata);
    exp_t e;
    e.name = name; e.lat = lat; e.rdata = rdata; e.err = err; e.psel = psel;
    e.chk_dn = chk_dn; e.pwrite = pwrite; e.paddr = paddr; e.pwdata = pwdata;
    return e;
  endfunction

  // Drives one upstream transfer; caller is positioned just after a posedge.
  // Latency counts cycles from the upstream setup cycle (setup cycle = 0).
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    obs_t o;
    o.lat = -1; o.rdata = '0; o.err = 1'b0; o.psel = '0; o.psel_resp = '0;
    o.onehot_ok = 1'b1; o.pwrite = 1'b0; o.paddr = '0; o.pwdata = '0;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
    @(posedge clk); #1;
    penable_i = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if ($countones(psel_o) > 1) o.onehot_ok = 1'b0;
      o.psel = o.psel | psel_o;
      if (psel_o != '0 && !penable_o) begin
        o.pwrite = pwrite_o; o.paddr = paddr_o; o.pwdata = pwdata_o;
      end
      if (pready_o) begin
        o.lat = c; o.rdata = prdata_o; o.err = pslverr_o; o.psel_resp = psel_o;
        break;
      end
    end
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({prdata_o, pready_o, pslverr_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== '0)
    begin
      failures++;
      $display("FAIL reset_outputs got psel=%b pready=%b penable=%b want all zero",
               psel_o, pready_o, penable_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({pready_o, psel_o, penable_o, pslverr_o} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got psel=%b pready=%b want zero", psel_o, pready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_transfers();
    exp_t e;
    obs_t o;
    slv_wait[2] = 0; slv_rdata[2] = 32'h0000_2222;
    exp_q.push_back(mk_exp("wr_s2", 3, 32'h0000_2222, 1'b0, 6'b000100, 1'b1, 1'b1, 12'h004,
                           32'hCAFE_0001));
    run_xfer(1'b1, 32'h1A10_2004, 32'hCAFE_0001);
    slv_wait[5] = 3; slv_rdata[5] = 32'h1234_5678;
    exp_q.push_back(mk_exp("rd_s5_wait3", 6, 32'h1234_5678, 1'b0, 6'b100000, 1'b1, 1'b0,
                           12'h010, 32'h0000_0000));
    run_xfer(1'b0, 32'h1A10_5010, 32'h0);
    exp_q.push_back(mk_exp("miss_base", 1, 32'h0, 1'b1, '0, 1'b0, 1'b0, '0, '0));
    run_xfer(1'b0, 32'h1A20_0000, 32'h0);
    exp_q.push_back(mk_exp("miss_idx7", 1, 32'h0, 1'b1, '0, 1'b0, 1'b0, '0, '0));
    run_xfer(1'b1, 32'h1A10_7000, 32'h7777_7777);
    exp_q.push_back(mk_exp("miss_idx6", 1, 32'h0, 1'b1, '0, 1'b0, 1'b0, '0, '0));
    run_xfer(1'b0, 32'h1A10_6000, 32'h0);
    // Slave error followed immediately by a clean back-to-back transfer.
    slv_wait[1] = 1; slv_err[1] = 1'b1; slv_rdata[1] = 32'h0000_1111;
    slv_wait[3] = 0; slv_rdata[3] = 32'hBEEF_0003;
    exp_q.push_back(mk_exp("wr_s1_err", 4, 32'h0000_1111, 1'b1, 6'b000010, 1'b1, 1'b1, 12'h008,
                           32'h5555_AAAA));
    exp_q.push_back(mk_exp("rd_s3_b2b", 3, 32'hBEEF_0003, 1'b0, 6'b001000, 1'b1, 1'b0, 12'hFFC,
                           32'h0000_0000));
    run_xfer(1'b1, 32'h1A10_1008, 32'h5555_AAAA);
    run_xfer(1'b0, 32'h1A10_3FFC, 32'h0);
    slv_err[1] = 1'b0;
    checks++;
    if (exp_q.size() != obs_q.size()) begin
      failures++;
      $display("FAIL sb_depth got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.lat !== e.lat) begin
        failures++; $display("FAIL %s latency got=%0d want=%0d", e.name, o.lat, e.lat);
      end
      checks++;
      if (o.err !== e.err) begin
        failures++; $display("FAIL %s pslverr got=%b want=%b", e.name, o.err, e.err);
      end
      checks++;
      if (o.rdata !== e.rdata) begin
        failures++; $display("FAIL %s prdata got=%h want=%h", e.name, o.rdata, e.rdata);
      end
      checks++;
      if (o.psel !== e.psel || !o.onehot_ok || o.psel_resp !== '0) begin
        failures++;
        $display("FAIL %s psel got=%b onehot=%b resp_psel=%b want=%b", e.name, o.psel,
                 o.onehot_ok, o.psel_resp, e.psel);
      end
      if (e.chk_dn) begin
        checks++;
        if (o.pwrite !== e.pwrite || o.paddr !== e.paddr || o.pwdata !== e.pwdata) begin
          failures++;
          $display("FAIL %s downstream got=%b/%h/%h want=%b/%h/%h", e.name, o.pwrite,
                   o.paddr, o.pwdata, e.pwrite, e.paddr, e.pwdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   seen_ready;
    slv_wait[5] = 5; slv_rdata[5] = 32'h5050_5050;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 32'h1A10_5000; pwdata_i = '0;
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (psel_o !== 6'b100000 || penable_o !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_in_access got psel=%b penable=%b want 100000/1", psel_o, penable_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({prdata_o, pready_o, pslverr_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== '0)
    begin
      failures++;
      $display("FAIL rstmid_same_cycle got psel=%b penable=%b pready=%b want zero",
               psel_o, penable_o, pready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    seen_ready = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (pready_o || psel_o != '0 || penable_o) seen_ready++;
    end
    checks++;
    if (seen_ready != 0) begin
      failures++; $display("FAIL rstmid_no_resp got=%0d active cycles want=0", seen_ready);
    end
    @(posedge clk); #1;
    slv_wait[3] = 1; slv_rdata[3] = 32'h0303_0303;
    run_xfer(1'b0, 32'h1A10_3020, 32'h0);
    o = obs_q.pop_front();
    checks++;
    if (o.lat !== 4 || o.rdata !== 32'h0303_0303 || o.err !== 1'b0 || o.psel !== 6'b001000)
    begin
      failures++;
      $display("FAIL rstmid_recover got lat=%0d data=%h err=%b psel=%b want 4/03030303/0/001000",
               o.lat, o.rdata, o.err, o.psel);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    obs_t o;
    slv_rdata[4] = 32'h4444_4444;
`ifdef APB_PERIPH_NODE_TIMEOUT_EN
    slv_wait[4] = 1000;
    exp_q.push_back(mk_exp("to_never", 18, 32'h0, 1'b1, 6'b010000, 1'b0, 1'b0, '0, '0));
    run_xfer(1'b0, 32'h1A10_4000, 32'h0);
    slv_wait[4] = 15;
    exp_q.push_back(mk_exp("to_ready16", 18, 32'h4444_4444, 1'b0, 6'b010000, 1'b0, 1'b0, '0, '0));
    run_xfer(1'b0, 32'h1A10_4000, 32'h0);
    slv_wait[4] = 16;
    exp_q.push_back(mk_exp("to_ready17", 18, 32'h0, 1'b1, 6'b010000, 1'b0, 1'b0, '0, '0));
    run_xfer(1'b0, 32'h1A10_4000, 32'h0);
`else
    slv_wait[4] = 20;
    exp_q.push_back(mk_exp("no_watchdog", 23, 32'h4444_4444, 1'b0, 6'b010000, 1'b0, 1'b0, '0,
                           '0));
    run_xfer(1'b0, 32'h1A10_4000, 32'h0);
`endif
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin
        failures++;
        $display("FAIL %s resp got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                 e.name, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
      end
      checks++;
      if (o.psel !== e.psel || o.psel_resp !== '0) begin
        failures++;
        $display("FAIL %s psel got=%b resp_psel=%b want=%b/000000", e.name, o.psel,
                 o.psel_resp, e.psel);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=hung want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int s = 0; s < NS; s++) begin
      slv_wait[s] = 0; slv_rdata[s] = 32'hA000_0000 | 32'(s); slv_err[s] = 1'b0;
    end
    rst = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_transfers();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
